ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage. Consumes operand_1/operand_2 as registered from ID into ID/EX, and owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU over 32 radix-2 iterations and requests a pipeline stall until the result is committed to HI/LO. It also handles MTHI/MTLO writes and supplies HI/LO to EX for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  abort in-flight operation (exception/branch squash)
start  input  1  EX instruction is MULT/MULTU/DIV/DIVU
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_1  input  WIDTH  rs value (multiplicand/dividend)
operand_2  input  WIDTH  rt value (multiplier/divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
stall_req  output  1  hold IF/ID/EX; combinational
done  output  1  one-cycle pulse: result committed to hi/lo this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is rst. On rst: state IDLE, counter 0, hi=0, lo=0, done=0. Reset mid-operation discards the operation with no hi/lo update.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + start (no flush), accepted at cycle T:
  - Latch the operand magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU.
  - Latch the result sign flags: quotient/product sign = sign1 XOR sign2; remainder sign = sign1 (signed ops only).
  - Go to MUL or DIV with counter=0.
  - Exception: DIV/DIVU with operand_2==0 goes directly to DONE at T+1 with lo=all-ones and hi=operand_1 (raw), for both signed and unsigned.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Counter: increments each iteration cycle. After counter reaches WIDTH-1, the sign correction (two's-complement negate per the latched flags) is applied. hi/lo load on the edge entering DONE.
- Normal latency: iterations run T+1..T+32; DONE (done=1, hi/lo valid) at T+33. DONE always returns to IDLE on the next cycle.
- Result mapping: MUL puts {hi,lo} = 64-bit product. DIV puts lo = quotient, hi = remainder.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude path and needs no special case.
- stall_req = ~flush & ((state==IDLE & start) | state==MUL | state==DIV). It is low in DONE so the instruction retires from EX at T+33.
- start outside IDLE is ignored. This cannot occur legally because the pipeline is stalled.
- flush in any state: next state IDLE, no hi/lo update, done stays 0. flush together with start in IDLE: start is not accepted.
- hi_we/lo_we write wdata on the edge in any state.
- If the result commit (edge entering DONE) coincides with hi_we/lo_we, the result wins.
- hi/lo hold their value otherwise. Reads are plain register outputs with no bypass; EX forwarding is handled elsewhere.
- done is registered: it is high exactly for the cycle the state is DONE.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at T -> stall_req high T..T+32; done=1 at T+33 with hi=0xFFFFFFFE, lo=0x00000001; done=0 at T+34.
2. MULT 0xFFFFFFFD (-3) x 5 -> at T+33 hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also MULT 7 x 6 -> hi=0, lo=0x2A.
3. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100 / 7 -> lo=14, hi=2.
4. DIVU 0x1234 / 0 at T -> done at T+1 with lo=0xFFFFFFFF, hi=0x1234; stall_req high only in T.
5. Preload hi=0xAAAA via MTHI. Start MULTU 3x3 at T; assert flush at T+10 -> stall_req low at T+10, state IDLE at T+11, done never pulses, hi=0xAAAA, lo unchanged. Repeat with rst at T+10 instead -> hi=lo=0.
6. MTLO wdata=0x55 asserted on the commit edge of MULTU 2x2 -> lo=4. MTHI 0x77 in IDLE -> hi=0x77 the next cycle with no stall.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit and its HI/LO registers.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, start, op, operand_1, operand_2, hi_we, lo_we, wdata,
    input  stall_req, done, hi, lo
  );

  modport slave (
    input  flush, start, op, operand_1, operand_2, hi_we, lo_we, wdata,
    output stall_req, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on operand magnitudes and applies the sign correction on the commit edge.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               qneg_q, rneg_q, done_q;

  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_s, div_sub;
  logic               qbit;
  logic [WIDTH-1:0]   div_rem_n;
  logic [2*WIDTH-1:0] iter_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
  logic               unused_bits_c;

  // Operand magnitudes and signs; unsigned ops treat operands as non-negative.
  always_comb begin
    s1   = ~bus.op[0] & bus.operand_1[WIDTH-1];
    s2   = ~bus.op[0] & bus.operand_2[WIDTH-1];
    mag1 = s1 ? (~bus.operand_1 + WIDTH'(1)) : bus.operand_1;
    mag2 = s2 ? (~bus.operand_2 + WIDTH'(1)) : bus.operand_2;
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    div_rem_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_sub   = div_rem_s - {1'b0, b_q};
    qbit      = (div_rem_s >= {1'b0, b_q});
    div_rem_n = qbit ? div_sub[WIDTH-1:0] : div_rem_s[WIDTH-1:0];
    iter_next = (state_q == S_MUL) ? {mul_sum, acc_q[WIDTH-1:1]}
                                   : {div_rem_n, acc_q[WIDTH-2:0], qbit};
    prod_fix  = qneg_q ? (~iter_next + (2*WIDTH)'(1)) : iter_next;
    quo_fix   = qneg_q ? (~iter_next[WIDTH-1:0] + WIDTH'(1)) : iter_next[WIDTH-1:0];
    rem_fix   = rneg_q ? (~iter_next[2*WIDTH-1:WIDTH] + WIDTH'(1))
                       : iter_next[2*WIDTH-1:WIDTH];
    res_hi    = (state_q == S_MUL) ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
    res_lo    = (state_q == S_MUL) ? prod_fix[WIDTH-1:0] : quo_fix;
    unused_bits_c = div_sub[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.op[1] && (bus.operand_2 == '0)) begin
              hi_q    <= bus.operand_1;
              lo_q    <= '1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              a_q     <= mag1;
              b_q     <= mag2;
              acc_q   <= {{WIDTH{1'b0}}, (bus.op[1] ? mag1 : mag2)};
              qneg_q  <= s1 ^ s2;
              rneg_q  <= s1;
              cnt_q   <= '0;
              state_q <= bus.op[1] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= iter_next;
            cnt_q <= cnt_q + CW'(1);
            // Final iteration: commit overrides any same-edge MTHI/MTLO.
            if (cnt_q == LAST) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_req = ~bus.flush & (((state_q == S_IDLE) & bus.start) |
                                       (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized checks of ex_muldiv against a plain-arithmetic HI/LO model.
module tb_ex_muldiv;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference {hi,lo} from 64-bit arithmetic; divide-by-zero yields {rs, all-ones}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = '0;
    case (o)
      2'd0: t = 64'(sa * sb);
      2'd1: t = ua * ub;
      2'd2: begin
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          t  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          t  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return t;
  endfunction

  // Issue one operation at cycle T and follow it through to the cycle after DONE.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit mt_commit);
    logic [63:0] exp;
    int          iter_bad;
    exp = model(o, a, b);
    bus.start     = 1'b1;
    bus.op        = o;
    bus.operand_1 = a;
    bus.operand_2 = b;
    #1;
    check({tag, " stall@T"}, 64'(bus.stall_req), 64'd1);
    step();
    bus.start     = 1'b0;
    bus.operand_1 = $urandom;
    bus.operand_2 = $urandom;
    if (!(o[1] && b == 32'd0)) begin
      iter_bad = 0;
      for (int k = 1; k <= 32; k++) begin
        if (bus.stall_req !== 1'b1 || bus.done !== 1'b0) iter_bad++;
        if (k == 32 && mt_commit) begin
          bus.hi_we = 1'b1;
          bus.lo_we = 1'b1;
          bus.wdata = 32'h55;
        end
        step();
      end
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      check({tag, " iter stall/done"}, 64'(iter_bad), 64'd0);
    end
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " stall@done"}, 64'(bus.stall_req), 64'd0);
    check({tag, " hi,lo"}, {bus.hi, bus.lo}, exp);
    step();
    check({tag, " done drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_lo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.flush = 1'b0; bus.start = 1'b0; bus.op = 2'd0;
    bus.operand_1 = '0; bus.operand_2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    step();
    step();
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset stall", 64'(bus.stall_req), 64'd0);
    rst = 1'b0;
    step();

    do_op("multu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_ff const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("mult_7x6", 2'd0, 32'd7, 32'd6, 1'b0);
    do_op("div_neg7", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
    do_op("divu_by0", 2'd3, 32'h1234, 32'd0, 1'b0);
    check("divu_by0 const", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
    do_op("div_by0", 2'd2, 32'hFFFF_0000, 32'd0, 1'b0);

    // Flush mid-operation leaves HI/LO untouched.
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA;
    step();
    bus.hi_we = 1'b0;
    check("mthi preload", 64'(bus.hi), 64'hAAAA);
    hold_lo = bus.lo;
    bus.start = 1'b1; bus.op = 2'd1; bus.operand_1 = 32'd3; bus.operand_2 = 32'd3;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    bus.flush = 1'b1;
    #1;
    check("flush stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.flush = 1'b0;
    #1;
    check("post-flush stall", 64'(bus.stall_req), 64'd0);
    for (int k = 0; k < 30; k++) begin
      if (bus.done !== 1'b0) check("flush no done", 64'(bus.done), 64'd0);
      step();
    end
    check("flush done", 64'(bus.done), 64'd0);
    check("flush hi", 64'(bus.hi), 64'hAAAA);
    check("flush lo", 64'(bus.lo), 64'(hold_lo));

    // Reset mid-operation clears HI/LO.
    bus.start = 1'b1; bus.op = 2'd1; bus.operand_1 = 32'd3; bus.operand_2 = 32'd3;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst-mid hi,lo", {bus.hi, bus.lo}, 64'd0);
    check("rst-mid done", 64'(bus.done), 64'd0);
    check("rst-mid stall", 64'(bus.stall_req), 64'd0);
    step();

    // start with flush in IDLE is not accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd3;
    bus.operand_1 = 32'd9; bus.operand_2 = 32'd0;
    #1;
    check("start+flush stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("start+flush done", 64'(bus.done), 64'd0);
    check("start+flush hi,lo", {bus.hi, bus.lo}, 64'd0);

    // Commit beats same-edge MTHI/MTLO; plain MTHI in IDLE does not stall.
    do_op("multu_2x2 mt", 2'd1, 32'd2, 32'd2, 1'b1);
    check("commit lo", 64'(bus.lo), 64'd4);
    bus.hi_we = 1'b1; bus.wdata = 32'h77;
    #1;
    check("mthi stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.hi_we = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h77);
    check("mthi lo kept", 64'(bus.lo), 64'd4);

    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
